// File: rtl/sys_timer_pkg.sv
// Shared register map, CTRL field layout and FSM encodings for the bus-mapped countdown timer.
package sys_timer_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_ACK    = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  // Only 01 reloads; 00 and 1x both run once.
  localparam logic [1:0] MODE_RELOAD = 2'b01;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_CNT  = 2'd2;
  localparam state_t ST_INT  = 2'd3;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sys_timer_regs.sv
// Bus-facing side of the timer: address decode, byte-merged CTRL/PRESET writes, ACK strobe, read mux.
module sys_timer_regs
  import sys_timer_pkg::*;
#(
  parameter logic [3:0] BASE_OFF = 4'h0,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel_i,
  input  logic [3:0]       addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       byteen_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             clr_en_i,
  output ctrl_t            ctrl_o,
  output logic             en_next_o,
  output logic [CNT_W-1:0] preset_o,
  output logic             ack_wr_o,
  output logic [31:0]      rdata_o
);

  logic [3:0]       local_off;
  logic [1:0]       reg_idx;
  logic             wr_any;
  logic             ctrl_wr;
  logic             preset_wr;
  logic             unused_off;
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;

  assign local_off  = addr_i - BASE_OFF;
  assign reg_idx    = local_off[3:2];
  assign unused_off = ^local_off[1:0];
  assign wr_any     = sel_i & (|byteen_i);
  // CTRL fields all live in byte lane 0; a write that skips that lane changes nothing.
  assign ctrl_wr    = wr_any & byteen_i[0] & (reg_idx == REG_CTRL);
  assign preset_wr  = wr_any & (reg_idx == REG_PRESET);
  assign ack_wr_o   = wr_any & (reg_idx == REG_ACK);

  always_comb begin
    ctrl_d = ctrl_q;
    if (clr_en_i) ctrl_d.en = 1'b0;
    // A software CTRL write on the same edge overrides the one-shot EN clear.
    if (ctrl_wr) begin
      ctrl_d.en   = wdata_i[CTRL_EN_BIT];
      ctrl_d.mode = wdata_i[CTRL_MODE_LSB +: 2];
      ctrl_d.im   = wdata_i[CTRL_IM_BIT];
    end
  end

  assign en_next_o = ctrl_wr ? wdata_i[CTRL_EN_BIT] : ctrl_q.en;
  assign preset_d  = preset_wr ? CNT_W'(byte_merge(32'(preset_q), wdata_i, byteen_i)) : preset_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q   <= '0;
      preset_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (sel_i) begin
      case (reg_idx)
        REG_CTRL: begin
          rdata_o[CTRL_EN_BIT]        = ctrl_q.en;
          rdata_o[CTRL_MODE_LSB +: 2] = ctrl_q.mode;
          rdata_o[CTRL_IM_BIT]        = ctrl_q.im;
        end
        REG_PRESET: rdata_o = 32'(preset_q);
        REG_COUNT:  rdata_o = 32'(count_i);
        default:    rdata_o = '0;
      endcase
    end
  end

  assign ctrl_o   = ctrl_q;
  assign preset_o = preset_q;

endmodule

// File: rtl/sys_timer.sv
// Countdown timer top: IDLE/LOAD/CNT/INT sequencer, COUNT register, sticky pending and registered irq.
module sys_timer
  import sys_timer_pkg::*;
#(
  parameter logic [3:0] BASE_OFF = 4'h0,
  parameter int         CNT_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  output logic        irq
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] preset_q;
  logic             pending_q, pending_d;
  logic             irq_q;
  logic             clr_en;
  logic             ack_wr;
  logic             en_next;
  ctrl_t            ctrl_q;

  sys_timer_regs #(
    .BASE_OFF (BASE_OFF),
    .CNT_W    (CNT_W)
  ) u_regs (
    .clk       (clk),
    .reset     (reset),
    .sel_i     (sel),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .byteen_i  (byteen),
    .count_i   (count_q),
    .clr_en_i  (clr_en),
    .ctrl_o    (ctrl_q),
    .en_next_o (en_next),
    .preset_o  (preset_q),
    .ack_wr_o  (ack_wr),
    .rdata_o   (rdata)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pending_d = pending_q;
    clr_en    = 1'b0;
    if (ack_wr) pending_d = 1'b0;
    case (state_q)
      // Looks at the incoming EN so the enabling write itself moves us into LOAD.
      ST_IDLE: if (en_next) state_d = ST_LOAD;
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q.en) begin
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          state_d   = ST_INT;
          pending_d = 1'b1;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      ST_INT: begin
        if (ctrl_q.mode == MODE_RELOAD) begin
          state_d = ST_LOAD;
        end else begin
          clr_en  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= pending_q & ctrl_q.im;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_sys_timer.sv
// Randomized self-checking bench for sys_timer against an arithmetic schedule model of COUNT, pending and irq.
module tb_sys_timer;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        sel    = 1'b0;
  logic [3:0]  addr   = '0;
  logic [31:0] wdata  = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_checks = 0;
  int n_fails  = 0;

  always #10 clk = ~clk;

  sys_timer dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .addr   (addr),
    .wdata  (wdata),
    .byteen (byteen),
    .rdata  (rdata),
    .irq    (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    sel = 1'b1; addr = a; wdata = d; byteen = be;
    tick();
    sel = 1'b0; byteen = '0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; addr = a; byteen = '0;
    #1;
    d = rdata;
    sel = 1'b0;
  endtask

  // Pending is set PRESET+2 edges after the enable write, then every PRESET+3 edges when reloading.
  function automatic bit is_set(input int k, input int p, input bit reload);
    int d;
    d = k - (p + 2);
    if (reload) return (d >= 0) && (d % (p + 3) == 0);
    return d == 0;
  endfunction

  // COUNT after edge k: PRESET at k=1, one less per edge, floored at 0; reload restarts every PRESET+3.
  function automatic logic [31:0] exp_count(input int k, input int p, input bit reload);
    int ph;
    ph = k - 1;
    if (reload) ph = ph % (p + 3);
    return (ph <= p) ? 32'(p - ph) : 32'd0;
  endfunction

  // policy: 0 = no ACK until teardown, 1 = random ACKs while pending, 2 = ACK on every set edge.
  task automatic run_timer(input int p, input logic [3:0] cv, input int policy);
    bit          reload, im, pend, set_k, irq_exp;
    int          kd, op;
    logic [31:0] d;
    reload = (cv[2:1] == 2'b01);
    im     = cv[3];
    kd     = reload ? 3 * (p + 3) + 2 : p + 5;
    $display("run p=%0d ctrl=0x%0h policy=%0d", p, cv, policy);
    bus_wr(4'h4, 32'(p), 4'hF);
    bus_wr(4'h0, 32'(cv), 4'h1);
    pend = 1'b0;
    for (int k = 1; k <= kd + 3; k++) begin
      set_k = (k <= kd) && is_set(k, p, reload);
      op = 0;
      if (k == kd) op = 3;
      else if (k == kd + 1) op = 1;
      else if (k < kd) begin
        if (policy == 2 && set_k) op = 1;
        else if (policy == 1 && pend && $urandom_range(0, 1) == 1) op = 1;
        else if (reload && $urandom_range(0, 7) == 0) op = 2;
      end
      case (op)
        1: begin
          sel = 1'b1; addr = 4'hC | 4'($urandom_range(0, 3));
          wdata = $urandom(); byteen = 4'($urandom_range(1, 15));
        end
        2, 3: begin
          sel = 1'b1; addr = 4'h0;
          wdata = ($urandom() & 32'hFFFF_FFF0) | 32'((op == 3) ? (cv & 4'hE) : cv);
          byteen = 4'($urandom_range(0, 15)) | 4'h1;
        end
        default: ;
      endcase
      tick();
      sel = 1'b0; byteen = '0;
      irq_exp = pend & im;
      pend = set_k ? 1'b1 : ((op == 1) ? 1'b0 : pend);
      check_eq($sformatf("irq k=%0d", k), 32'(irq), 32'(irq_exp));
      if (k <= kd) begin
        bus_rd(4'h8, d);
        check_eq($sformatf("count k=%0d", k), d, exp_count(k, p, reload));
      end
    end
    bus_rd(4'h0, d);
    check_eq("ctrl_after", d, 32'(cv & 4'hE));
  endtask

  initial begin
    logic [31:0] d, base, nw, exp;
    logic [3:0]  be;

    tick(); tick();
    reset = 1'b1;
    tick();

    bus_rd(4'h0, d); check_eq("rst_ctrl", d, 32'h0);
    bus_rd(4'h4, d); check_eq("rst_preset", d, 32'h0);
    bus_rd(4'h8, d); check_eq("rst_count", d, 32'h0);
    bus_rd(4'hC, d); check_eq("rst_ack", d, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);

    bus_wr(4'h4, 32'h1122_3344, 4'hF);
    bus_wr(4'h4, 32'h0000_AA00, 4'b0010);
    bus_rd(4'h4, d); check_eq("byte_merge", d, 32'h1122_AA44);
    addr = 4'h4; #1;
    check_eq("nosel_rdata", rdata, 32'h0);
    bus_wr(4'h8, 32'hFFFF_FFFF, 4'hF);
    bus_rd(4'h8, d); check_eq("count_ro", d, 32'h0);
    for (int i = 0; i < 6; i++) begin
      base = $urandom(); nw = $urandom(); be = 4'($urandom_range(0, 15));
      bus_wr(4'h4, base, 4'hF);
      bus_wr(4'h4 | 4'($urandom_range(0, 3)), nw, be);
      exp = base;
      for (int b = 0; b < 4; b++) if (be[b]) exp[8*b +: 8] = nw[8*b +: 8];
      bus_rd(4'h4, d); check_eq($sformatf("byte_rand be=%b", be), d, exp);
    end

    run_timer(5, 4'h9, 0);
    run_timer(0, 4'h9, 0);
    run_timer(2, 4'hB, 2);
    run_timer(2, 4'hB, 1);
    for (int i = 0; i < 10; i++) begin
      run_timer(int'($urandom_range(0, 9)),
                {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1},
                int'($urandom_range(0, 2)));
    end

    $display("masked p=1");
    bus_wr(4'h4, 32'h1, 4'hF);
    bus_wr(4'h0, 32'h1, 4'h1);
    repeat (6) tick();
    check_eq("masked_irq", 32'(irq), 32'h0);
    bus_wr(4'h0, 32'h8, 4'h1);
    tick();
    check_eq("unmask_irq", 32'(irq), 32'h1);
    bus_wr(4'hC, 32'h0, 4'h1);
    tick();
    check_eq("unmask_ack", 32'(irq), 32'h0);
    bus_wr(4'h0, 32'h0, 4'hF);

    $display("async reset mid-count");
    bus_wr(4'h4, 32'h40, 4'hF);
    bus_wr(4'h0, 32'h9, 4'h1);
    repeat (33) tick();
    bus_rd(4'h8, d); check_eq("pre_rst_count", d, 32'h20);
    #2 reset = 1'b0;
    #1;
    bus_rd(4'h8, d); check_eq("arst_count", d, 32'h0);
    bus_rd(4'h0, d); check_eq("arst_ctrl", d, 32'h0);
    check_eq("arst_irq", 32'(irq), 32'h0);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    bus_rd(4'h8, d); check_eq("post_rst_count", d, 32'h0);
    bus_rd(4'h4, d); check_eq("post_rst_preset", d, 32'h0);
    check_eq("post_rst_irq", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sys_timer.md
Name: sys_timer

Overview:
- Memory-mapped countdown timer on the CPU data bus, behind the system bridge.
- Its `irq` output drives the CPU core's external `interrupt` input, which CP0 samples. It is the upstream source of the interrupt the core consumes.
- Software programs it with word stores (byte-enable style, same as the data bus) and clears the interrupt by writing the ACK register. This matches the "write to the device acknowledges the interrupt" protocol used in system test.

Parameters:
- `BASE_OFF`, 4'h0: unused high-order decode is done by the bridge; kept for documentation of the local offset origin.
- `CNT_W`, 32: width of the PRESET and COUNT registers.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted). Same port name as the rest of the codebase; polarity and asynchronous behaviour are fixed for this block.
- `sel`  in  1  bridge select: this device is addressed this cycle.
- `addr`  in  4  byte offset within the device. `addr[3:2]` selects the register; `addr[1:0]` is ignored.
- `wdata`  in  32  store data, already byte-lane aligned.
- `byteen`  in  4  byte enables. A write occurs when `sel` is high and any bit of `byteen` is set.
- `rdata`  out  32  read data, combinational.
- `irq`  out  1  interrupt request to the core, registered.

Behaviour:
- Register map (`addr[3:2]`):
  - 0 CTRL: bit0 EN, bits2:1 MODE (00 one-shot, 01 auto-reload, 1x behaves as one-shot), bit3 IM (interrupt mask, 1 = enabled). Bits 31:4 read 0.
  - 1 PRESET: read/write.
  - 2 COUNT: read-only; writes are ignored.
  - 3 ACK: write-only; any write clears `pending`. Reads return 0.
- Writes merge per byte: a byte lane is updated only where `byteen[i]` is set.
- `rdata`: when `sel` is low, `rdata` = 0. Otherwise it returns the selected register's current value.
- `irq` = `pending` & IM, registered, so there is no combinational path from bus inputs.
- Reset (asynchronous, `reset` = 0): state IDLE, CTRL=0, PRESET=0, COUNT=0, `pending`=0, `irq`=0. Reset asserted mid-count aborts immediately. After release the timer stays idle until EN is written again.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: go to LOAD when EN=1.
  - LOAD: COUNT <= PRESET, then go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT frozen.
    - Else if COUNT==0, go to INT and set `pending` <= 1.
    - Else COUNT <= COUNT-1.
  - INT:
    - One-shot: clear EN, go to IDLE.
    - Auto-reload: go to LOAD.
- Timing:
  - The CTRL write that sets EN lands at edge 0, and LOAD is entered at that edge.
  - COUNT=PRESET after edge 1.
  - COUNT reaches 0 after edge PRESET+1.
  - `pending`/INT after edge PRESET+2.
  - `irq` after edge PRESET+3, one register stage.
- Auto-reload period: PRESET+3 cycles between successive `pending` sets.
- PRESET=0: the FSM passes LOAD → CNT → INT with no decrement. `irq` rises 3 edges after the enable write.
- COUNT is unsigned, 32-bit, and never wraps below 0.
- A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
- Writing CTRL with EN=1 while in CNT does not restart the count.
- If an ACK write and a `pending` set occur on the same edge, the set wins.
- `pending` is sticky. It is independent of IM: masking hides `irq` but does not lose the event. Unmasking later raises `irq` on the next edge.
- The FSM clearing EN in INT and a CTRL write on the same edge: the bus write wins.

Decomposition:
- Shared package `sys_timer_pkg`:
  - register offsets CTRL/PRESET/COUNT/ACK;
  - CTRL bit positions;
  - MODE encodings;
  - FSM state enum (2-bit).
- One natural sub-module, `sys_timer_regs`: bus decode, byte-merge writes, and the read mux.
- The FSM, counter and `pending`/`irq` logic stay in the top module.

Test Plan:
- Reset release, then reads of all 4 offsets with `sel`=1 -> `rdata`=0 every time. With `sel`=0 -> `rdata`=0. `irq`=0.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM) -> `irq` rises exactly 8 edges after the CTRL write edge. CTRL reads 0x8 afterwards. `irq` holds until a write to offset 0xC, then drops 1 edge later.
- Auto-reload: PRESET=2, CTRL=0xB -> `pending` sets every 5 cycles. ACK each time. 3 `irq` pulses observed in 15 cycles. Same-edge ACK and set -> `irq` stays high.
- Masked: PRESET=1, CTRL=0x1 -> `irq` stays 0 while `pending`=1. A later CTRL write of 0x8 -> `irq`=1 on the next edge.
- Byte writes: PRESET=0x11223344, then `byteen`=4'b0010 with `wdata`=0x0000AA00 -> PRESET reads 0x1122AA44. A write to COUNT is ignored.
- Asynchronous reset pulse while in CNT with COUNT=0x20 -> immediately COUNT=0, state IDLE, `irq`=0, independent of `clk`. No counting after release.
